mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/lh/lb/sw/sh/sb).
- Grants one access at a time and drives the memory request/ready handshake.
- Generates byte enables, lane replication and read-lane extraction.
- Stalls the requesting stages until their access completes, and discards in-flight fetches cancelled by a taken branch or jump (PCSrc).
- Sits between the pipeline stage registers and the memory model; its IF_Stall/MEM_Stall outputs feed the pipeline-register control logic.

Parameters:
TIMEOUT, 64, max cycles a granted access may wait for Mem_Ready before abort
ERR_DATA, 32'h00000000, data returned on an aborted access

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
PCSrc  in  1  taken branch/jump; cancels the fetch
IF_Req  in  1  fetch request, held until IF_Valid
IF_Addr  in  32  fetch address (word aligned)
IF_Data  out  32  fetched instruction
IF_Valid  out  1  one-cycle fetch-complete pulse
IF_Stall  out  1  hold PC and IF/ID register
MEM_Req  in  1  data access request, held until MEM_Valid
MEM_Write  in  1  1 = store, 0 = load
MEM_Size  in  2  00 word, 01 half, 10 byte, 11 illegal
MEM_Addr  in  32  byte address
MEM_WData  in  32  store data, right-justified
MEM_RData  out  32  load data, right-justified, zero-extended
MEM_Valid  out  1  one-cycle access-complete pulse
MEM_Stall  out  1  hold all stages up to and including EX/MEM
Misalign  out  1  one-cycle pulse: illegal size or alignment, access dropped
Bus_Err  out  1  sticky timeout flag
Mem_Req  out  1  memory request
Mem_Write  out  1  memory write strobe
Mem_Addr  out  32  word address (byte address with [1:0] = 00)
Mem_WData  out  32  lane-replicated write data
Mem_ByteEn  out  4  byte enables; bit k = byte lane k (little-endian)
Mem_Ready  in  1  access completes on the cycle this is sampled high
Mem_RData  in  32  read data, valid with Mem_Ready

Behaviour:
- Reset: state IDLE. All outputs, discard flag and timeout counter = 0. Reset mid-access drops Mem_Req at the same edge; no Valid pulse. Bus_Err cleared only by Reset.
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE, decision priority:
  - MEM_Req with legal access: latch the access, go to MEM_BUSY.
  - MEM_Req with illegal access: pulse Misalign next cycle, pulse MEM_Valid with MEM_RData = 0, stay IDLE.
  - else IF_Req && !PCSrc: go to IF_BUSY.
  - MEM beats IF on a simultaneous request.
- Memory port outputs are registered. Mem_Req rises the cycle after the grant. Addr, WData, ByteEn and Write stay stable while Mem_Req = 1.
- Completion: in BUSY, Mem_Ready = 1 ends the access. Next cycle: Mem_Req = 0, the Valid pulse and data are presented, and the state is IDLE.
- One idle cycle between back-to-back accesses.
- Minimum access latency from grant to Valid is 2 cycles with Mem_Ready tied high.
- Byte enables and write data (addr[1:0] = a):
  - word: a must be 00; ByteEn = 1111.
  - half: a[0] must be 0; ByteEn = 0011 (a[1]=0) or 1100 (a[1]=1); WData = {2{h}}.
  - byte: ByteEn = 0001 << a; WData = {4{b}}.
- Read data: MEM_RData = selected lane(s) shifted to bit 0, upper bits zero. Sign extension is done downstream. Fetches return Mem_RData unmodified.
- Loads drive Mem_WData = 0 and ByteEn = 1111 regardless of size; lane selection happens on return.
- Fetch with IF_Addr[1:0] != 00: Misalign pulse, no access, IF_Valid pulse with IF_Data = 0.
- PCSrc while in IF_BUSY: set the discard flag. The access still completes on the memory side, but IF_Valid is suppressed, and IF_Data is not updated.
  - PCSrc on the same cycle as Mem_Ready is also discarded.
- Stalls are combinational:
  - IF_Stall = IF_Req & ~IF_Valid.
  - MEM_Stall = MEM_Req & ~MEM_Valid.
  - A pending MEM access also forces IF_Stall = 1.
- Timeout: the counter increments each BUSY cycle without Mem_Ready and clears on entering BUSY. When it reaches TIMEOUT:
  - Drop Mem_Req and set Bus_Err.
  - Pulse the owner's Valid with data ERR_DATA (suppressed if discarded).
  - Return to IDLE.
- IF_Data/MEM_RData hold their last value between pulses.

Test Plan:
- Fetch only: IF_Addr = 0x40, Mem_Ready tied 1, Mem_RData = 0x20080005 -> Mem_Req high 1 cycle with Mem_Addr = 0x40, IF_Valid 2 cycles after IF_Req, IF_Data = 0x20080005, IF_Stall high for exactly 2 cycles.
- Simultaneous IF_Req and MEM_Req (lw 0x100) -> MEM served first (MEM_Valid at cycle 2), then 1 idle cycle, then the fetch (IF_Valid at cycle 5); IF_Stall stays high throughout.
- sb 0xAB at 0x103 -> ByteEn = 1000, WData = 0xABABABAB. lh from 0x102 with Mem_RData = 0x1234ABCD -> MEM_RData = 0x00001234.
- Misaligned lw at 0x101 -> Misalign pulse, no Mem_Req, MEM_Valid with MEM_RData = 0. sh at 0x103 gives the same response.
- PCSrc pulses during IF_BUSY with Mem_Ready delayed 3 cycles -> no IF_Valid, state returns to IDLE, the next IF_Req is granted normally.
- Mem_Ready held 0 with TIMEOUT = 4 -> after 4 busy cycles Mem_Req drops, Bus_Err = 1 until Reset, Valid pulses with ERR_DATA. Reset asserted mid-access -> Mem_Req = 0 at the next edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the MEM stage. One access at a time, MEM wins ties. Memory-side
// outputs are registered, and every access is followed by one idle cycle.
// Fetches cancelled by PCSrc still finish on the bus but are not reported.
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCSrc,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic [31:0] IF_Data,
  output logic        IF_Valid,
  output logic        IF_Stall,
  input  logic        MEM_Req,
  input  logic        MEM_Write,
  input  logic [1:0]  MEM_Size,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic [31:0] MEM_RData,
  output logic        MEM_Valid,
  output logic        MEM_Stall,
  output logic        Misalign,
  output logic        Bus_Err,
  output logic        Mem_Req,
  output logic        Mem_Write,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_ByteEn,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_RData
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    IF_BUSY  = 2'b01,
    MEM_BUSY = 2'b10
  } state_t;

  // Size/alignment legality of a data access.
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      2'b00:   ok = (a == 2'b00);
      2'b01:   ok = ~a[0];
      2'b10:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by a store.
  function automatic logic [3:0] store_byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b1111;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated onto every lane so the byte enables pick the right one.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = wd;
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = {4{wd[7:0]}};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Selected load lane(s) moved down to bit 0, zero-extended.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [31:0] d;
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (size)
      2'b00:   d = rd;
      2'b01:   d = a[1] ? {16'h0000, rd[31:16]} : {16'h0000, rd[15:0]};
      2'b10:   d = {24'h00_0000, sh[7:0]};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] tmo_cnt_r;
  logic          discard_r;
  logic          idle_gap_r;
  logic [1:0]    lat_size_r;
  logic [1:0]    lat_lo_r;

  logic          can_grant_s;
  logic          mem_start_s;
  logic          mem_bad_s;
  logic          if_take_s;
  logic          if_start_s;
  logic          if_bad_s;
  logic          busy_s;
  logic [CW-1:0] cnt_inc_s;
  logic          timeout_s;
  logic          done_s;

  logic          mem_req_next_s;
  logic          mem_write_next_s;
  logic [31:0]   mem_addr_next_s;
  logic [31:0]   mem_wdata_next_s;
  logic [3:0]    mem_byte_en_next_s;
  logic          if_valid_next_s;
  logic [31:0]   if_data_next_s;
  logic          mem_valid_next_s;
  logic [31:0]   mem_rdata_next_s;
  logic          misalign_next_s;
  logic          bus_err_next_s;
  logic          discard_next_s;
  logic [CW-1:0] tmo_cnt_next_s;
  logic          idle_gap_next_s;
  logic [1:0]    lat_size_next_s;
  logic [1:0]    lat_lo_next_s;

  // Grant decisions: only from IDLE, never in the idle cycle after an access.
  assign can_grant_s = (state_r == IDLE) && !idle_gap_r;
  assign mem_start_s = can_grant_s && MEM_Req && access_legal(MEM_Size, MEM_Addr[1:0]);
  assign mem_bad_s   = can_grant_s && MEM_Req && !access_legal(MEM_Size, MEM_Addr[1:0]);
  assign if_take_s   = can_grant_s && !MEM_Req && IF_Req && !PCSrc;
  assign if_start_s  = if_take_s && (IF_Addr[1:0] == 2'b00);
  assign if_bad_s    = if_take_s && (IF_Addr[1:0] != 2'b00);

  assign busy_s    = (state_r != IDLE);
  assign cnt_inc_s = tmo_cnt_r + CW'(1);
  assign timeout_s = busy_s && !Mem_Ready && (cnt_inc_s == CW'(TIMEOUT));
  assign done_s    = busy_s && (Mem_Ready || timeout_s);

  // A pending data access holds the front end as well.
  assign MEM_Stall = MEM_Req & ~MEM_Valid;
  assign IF_Stall  = (IF_Req & ~IF_Valid) | (MEM_Req & ~MEM_Valid);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_start_s) begin
          state_next_s = MEM_BUSY;
        end else if (if_start_s) begin
          state_next_s = IF_BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    mem_req_next_s     = Mem_Req;
    mem_write_next_s   = Mem_Write;
    mem_addr_next_s    = Mem_Addr;
    mem_wdata_next_s   = Mem_WData;
    mem_byte_en_next_s = Mem_ByteEn;
    if_valid_next_s    = 1'b0;
    if_data_next_s     = IF_Data;
    mem_valid_next_s   = 1'b0;
    mem_rdata_next_s   = MEM_RData;
    misalign_next_s    = 1'b0;
    bus_err_next_s     = Bus_Err;
    discard_next_s     = discard_r;
    tmo_cnt_next_s     = tmo_cnt_r;
    idle_gap_next_s    = 1'b0;
    lat_size_next_s    = lat_size_r;
    lat_lo_next_s      = lat_lo_r;
    case (state_r)
      IDLE: begin
        if (mem_start_s) begin
          mem_req_next_s     = 1'b1;
          mem_write_next_s   = MEM_Write;
          mem_addr_next_s    = {MEM_Addr[31:2], 2'b00};
          mem_wdata_next_s   = MEM_Write ? store_lanes(MEM_Size, MEM_WData) : 32'h0000_0000;
          mem_byte_en_next_s = MEM_Write ? store_byte_en(MEM_Size, MEM_Addr[1:0]) : 4'b1111;
          lat_size_next_s    = MEM_Size;
          lat_lo_next_s      = MEM_Addr[1:0];
          tmo_cnt_next_s     = {CW{1'b0}};
          discard_next_s     = 1'b0;
        end else if (mem_bad_s) begin
          misalign_next_s  = 1'b1;
          mem_valid_next_s = 1'b1;
          mem_rdata_next_s = 32'h0000_0000;
          idle_gap_next_s  = 1'b1;
        end else if (if_start_s) begin
          mem_req_next_s     = 1'b1;
          mem_write_next_s   = 1'b0;
          mem_addr_next_s    = IF_Addr;
          mem_wdata_next_s   = 32'h0000_0000;
          mem_byte_en_next_s = 4'b1111;
          tmo_cnt_next_s     = {CW{1'b0}};
          discard_next_s     = 1'b0;
        end else if (if_bad_s) begin
          misalign_next_s = 1'b1;
          if_valid_next_s = 1'b1;
          if_data_next_s  = 32'h0000_0000;
          idle_gap_next_s = 1'b1;
        end else begin
          idle_gap_next_s = 1'b0;
        end
      end
      IF_BUSY: begin
        if (done_s) begin
          mem_req_next_s   = 1'b0;
          mem_write_next_s = 1'b0;
          idle_gap_next_s  = 1'b1;
          tmo_cnt_next_s   = {CW{1'b0}};
          discard_next_s   = 1'b0;
          bus_err_next_s   = Bus_Err | timeout_s;
          // A branch on the completing cycle cancels the result as well.
          if (!discard_r && !PCSrc) begin
            if_valid_next_s = 1'b1;
            if_data_next_s  = timeout_s ? ERR_DATA : Mem_RData;
          end else begin
            if_valid_next_s = 1'b0;
          end
        end else begin
          tmo_cnt_next_s = cnt_inc_s;
          discard_next_s = discard_r | PCSrc;
        end
      end
      MEM_BUSY: begin
        if (done_s) begin
          mem_req_next_s   = 1'b0;
          mem_write_next_s = 1'b0;
          idle_gap_next_s  = 1'b1;
          tmo_cnt_next_s   = {CW{1'b0}};
          bus_err_next_s   = Bus_Err | timeout_s;
          mem_valid_next_s = 1'b1;
          if (timeout_s) begin
            mem_rdata_next_s = ERR_DATA;
          end else if (!Mem_Write) begin
            mem_rdata_next_s = load_extract(lat_size_r, lat_lo_r, Mem_RData);
          end else begin
            mem_rdata_next_s = MEM_RData;
          end
        end else begin
          tmo_cnt_next_s = cnt_inc_s;
        end
      end
      default: begin
        mem_req_next_s   = 1'b0;
        mem_write_next_s = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Mem_Req    <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_Addr   <= 32'h0000_0000;
      Mem_WData  <= 32'h0000_0000;
      Mem_ByteEn <= 4'b0000;
      IF_Valid   <= 1'b0;
      IF_Data    <= 32'h0000_0000;
      MEM_Valid  <= 1'b0;
      MEM_RData  <= 32'h0000_0000;
      Misalign   <= 1'b0;
      Bus_Err    <= 1'b0;
      discard_r  <= 1'b0;
      tmo_cnt_r  <= {CW{1'b0}};
      idle_gap_r <= 1'b0;
      lat_size_r <= 2'b00;
      lat_lo_r   <= 2'b00;
    end else begin
      Mem_Req    <= mem_req_next_s;
      Mem_Write  <= mem_write_next_s;
      Mem_Addr   <= mem_addr_next_s;
      Mem_WData  <= mem_wdata_next_s;
      Mem_ByteEn <= mem_byte_en_next_s;
      IF_Valid   <= if_valid_next_s;
      IF_Data    <= if_data_next_s;
      MEM_Valid  <= mem_valid_next_s;
      MEM_RData  <= mem_rdata_next_s;
      Misalign   <= misalign_next_s;
      Bus_Err    <= bus_err_next_s;
      discard_r  <= discard_next_s;
      tmo_cnt_r  <= tmo_cnt_next_s;
      idle_gap_r <= idle_gap_next_s;
      lat_size_r <= lat_size_next_s;
      lat_lo_r   <= lat_lo_next_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// transactions and Valid data; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        Clk = 1'b0;
  logic        Reset, PCSrc, IF_Req, MEM_Req, MEM_Write, Mem_Ready;
  logic [31:0] IF_Addr, MEM_Addr, MEM_WData, Mem_RData;
  logic [1:0]  MEM_Size;
  logic [31:0] IF_Data, MEM_RData, Mem_Addr, Mem_WData;
  logic        IF_Valid, IF_Stall, MEM_Valid, MEM_Stall, Misalign, Bus_Err;
  logic        Mem_Req, Mem_Write;
  logic [3:0]  Mem_ByteEn;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } port_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } mexp_t;

  port_t       port_q[$];
  logic [31:0] if_q[$];
  mexp_t       mem_q[$];
  int          mis_exp = 0;
  int          checks = 0;
  int          errors = 0;

  logic        ready_en;
  int          ready_delay;
  int          wait_cnt = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .Clk(Clk), .Reset(Reset), .PCSrc(PCSrc),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Data(IF_Data), .IF_Valid(IF_Valid), .IF_Stall(IF_Stall),
    .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Size(MEM_Size), .MEM_Addr(MEM_Addr),
    .MEM_WData(MEM_WData), .MEM_RData(MEM_RData), .MEM_Valid(MEM_Valid), .MEM_Stall(MEM_Stall),
    .Misalign(Misalign), .Bus_Err(Bus_Err),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_ByteEn(Mem_ByteEn), .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData)
  );

  // Memory model: ready after ready_delay cycles of Mem_Req.
  assign Mem_Ready = Mem_Req & ready_en & (wait_cnt >= ready_delay);

  // Count consecutive cycles Mem_Req has been high.
  always @(posedge Clk) begin
    if (!Mem_Req) wait_cnt <= 0;
    else          wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: memory handshakes, Valid pulses and Misalign pulses against the queues.
  always @(negedge Clk) begin
    port_t e;
    mexp_t m;
    if (Mem_Req && Mem_Ready) begin
      if (port_q.size() == 0) begin
        check("port_unexpected", 32'd1, 32'd0);
      end else begin
        e = port_q.pop_front();
        check("port_write", {31'd0, Mem_Write}, {31'd0, e.wr});
        check("port_addr", Mem_Addr, e.addr);
        check("port_byteen", {28'd0, Mem_ByteEn}, {28'd0, e.be});
        check("port_wdata", Mem_WData, e.wdata);
      end
    end else if (port_q.size() > 0) begin
      Mem_RData = port_q[0].rdata;
    end
    if (IF_Valid) begin
      if (if_q.size() == 0) check("if_valid_unexpected", 32'd1, 32'd0);
      else check("if_data", IF_Data, if_q.pop_front());
    end
    if (MEM_Valid) begin
      if (mem_q.size() == 0) begin
        check("mem_valid_unexpected", 32'd1, 32'd0);
      end else begin
        m = mem_q.pop_front();
        if (m.chk) check("mem_rdata", MEM_RData, m.data);
      end
    end
    if (Misalign) begin
      if (mis_exp == 0) check("misalign_unexpected", 32'd1, 32'd0);
      else begin
        checks++;
        mis_exp--;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic mem_access(input string name, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [31:0] exp_rdata,
                            input logic legal, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input int exp_lat);
    int lat = 0;
    int reqcnt = 0;
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    if (legal && ready_en) port_q.push_back('{wr, waddr, exp_be, exp_wdata, rdata});
    if (!legal) mis_exp++;
    mem_q.push_back('{(!wr || !legal), legal ? exp_rdata : 32'h0});
    MEM_Req = 1'b1; MEM_Write = wr; MEM_Size = size; MEM_Addr = addr; MEM_WData = wdata;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      step();
      if (Mem_Req) reqcnt++;
      if (MEM_Valid) lat = c;
    end
    step();
    MEM_Req = 1'b0;
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_reqcycles"}, 32'(reqcnt), legal ? 32'(exp_lat - 1) : 32'd0);
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] rdata,
                       input logic legal, input int exp_lat);
    int lat = 0;
    int reqcnt = 0;
    int stall = 0;
    if (legal) port_q.push_back('{1'b0, addr, 4'b1111, 32'h0, rdata});
    else mis_exp++;
    if_q.push_back(legal ? rdata : 32'h0);
    IF_Req = 1'b1; IF_Addr = addr;
    #1;
    if (IF_Stall) stall++;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      step();
      if (Mem_Req) reqcnt++;
      if (IF_Stall) stall++;
      if (IF_Valid) lat = c;
    end
    step();
    IF_Req = 1'b0;
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_stall"}, 32'(stall), 32'(exp_lat));
    check({name, "_reqcycles"}, 32'(reqcnt), legal ? 32'(exp_lat - 1) : 32'd0);
  endtask

  initial begin
    int mem_at, if_at, stall, lat, vcnt;
    logic drop;
    Reset = 1'b1; PCSrc = 1'b0; IF_Req = 1'b0; IF_Addr = 32'h0;
    MEM_Req = 1'b0; MEM_Write = 1'b0; MEM_Size = 2'b00; MEM_Addr = 32'h0; MEM_WData = 32'h0;
    Mem_RData = 32'h0; ready_en = 1'b1; ready_delay = 0;
    step(); step();
    check("rst_if_valid", {31'd0, IF_Valid}, 32'd0);
    check("rst_mem_valid", {31'd0, MEM_Valid}, 32'd0);
    check("rst_mem_req", {31'd0, Mem_Req}, 32'd0);
    check("rst_bus_err", {31'd0, Bus_Err}, 32'd0);
    check("rst_misalign", {31'd0, Misalign}, 32'd0);
    check("rst_byteen", {28'd0, Mem_ByteEn}, 32'd0);
    check("rst_if_data", IF_Data, 32'h0);
    check("rst_mem_rdata", MEM_RData, 32'h0);
    check("rst_stalls", {30'd0, IF_Stall, MEM_Stall}, 32'd0);
    Reset = 1'b0;
    step();

    fetch("fetch40", 32'h0000_0040, 32'h2008_0005, 1'b1, 2);

    // Simultaneous requests: MEM first, idle cycle, then the fetch.
    port_q.push_back('{1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'h1122_3344});
    port_q.push_back('{1'b0, 32'h0000_0080, 4'b1111, 32'h0, 32'h5566_7788});
    mem_q.push_back('{1'b1, 32'h1122_3344});
    if_q.push_back(32'h5566_7788);
    MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Size = 2'b00; MEM_Addr = 32'h0000_0100;
    IF_Req = 1'b1; IF_Addr = 32'h0000_0080;
    #1;
    stall = IF_Stall ? 1 : 0;
    mem_at = 0; if_at = 0; drop = 1'b0;
    for (int c = 1; c <= 30 && if_at == 0; c++) begin
      step();
      if (IF_Stall) stall++;
      if (IF_Valid) if_at = c;
      if (drop) begin MEM_Req = 1'b0; drop = 1'b0; end
      if (MEM_Valid) begin mem_at = c; drop = 1'b1; end
    end
    step();
    IF_Req = 1'b0; MEM_Req = 1'b0;
    check("simul_mem_at", 32'(mem_at), 32'd2);
    check("simul_if_at", 32'(if_at), 32'd5);
    check("simul_if_stall", 32'(stall), 32'd5);

    mem_access("sb103", 1'b1, 2'b10, 32'h0000_0103, 32'h0000_00AB, 32'h0, 32'h0, 1'b1, 4'b1000, 32'hABAB_ABAB, 2);
    mem_access("sh102", 1'b1, 2'b01, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 2);
    mem_access("sw104", 1'b1, 2'b00, 32'h0000_0104, 32'h1122_3344, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h1122_3344, 2);
    mem_access("lh102", 1'b0, 2'b01, 32'h0000_0102, 32'h0, 32'h1234_ABCD, 32'h0000_1234, 1'b1, 4'b1111, 32'h0, 2);
    mem_access("lh100", 1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h1234_ABCD, 32'h0000_ABCD, 1'b1, 4'b1111, 32'h0, 2);
    mem_access("lb101", 1'b0, 2'b10, 32'h0000_0101, 32'h0, 32'h1234_ABCD, 32'h0000_00AB, 1'b1, 4'b1111, 32'h0, 2);
    mem_access("lb103", 1'b0, 2'b10, 32'h0000_0103, 32'h0, 32'h1234_ABCD, 32'h0000_0012, 1'b1, 4'b1111, 32'h0, 2);
    mem_access("lw108", 1'b0, 2'b00, 32'h0000_0108, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b1, 4'b1111, 32'h0, 2);
    mem_access("lw101_bad", 1'b0, 2'b00, 32'h0000_0101, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1);
    mem_access("sh103_bad", 1'b1, 2'b01, 32'h0000_0103, 32'h0000_5555, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1);
    mem_access("size11_bad", 1'b0, 2'b11, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1);
    fetch("fetch42_bad", 32'h0000_0042, 32'h0, 1'b0, 1);

    // Branch during a slow fetch: result dropped, redirected fetch served next.
    ready_delay = 3;
    port_q.push_back('{1'b0, 32'h0000_0200, 4'b1111, 32'h0, 32'hCAFE_F00D});
    port_q.push_back('{1'b0, 32'h0000_0300, 4'b1111, 32'h0, 32'h0BAD_C0DE});
    if_q.push_back(32'h0BAD_C0DE);
    IF_Req = 1'b1; IF_Addr = 32'h0000_0200;
    step();
    PCSrc = 1'b1; IF_Addr = 32'h0000_0300;
    step();
    PCSrc = 1'b0;
    lat = 0;
    for (int c = 3; c <= 40 && lat == 0; c++) begin
      step();
      if (IF_Valid) lat = c;
    end
    step();
    IF_Req = 1'b0;
    check("discard_redirect_lat", 32'(lat), 32'd11);

    // Branch on the same cycle as Mem_Ready.
    ready_delay = 0;
    port_q.push_back('{1'b0, 32'h0000_0400, 4'b1111, 32'h0, 32'h7777_7777});
    IF_Req = 1'b1; IF_Addr = 32'h0000_0400;
    step();
    PCSrc = 1'b1; IF_Req = 1'b0;
    step();
    PCSrc = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (IF_Valid) vcnt++;
      step();
    end
    check("discard_same_cycle_valids", 32'(vcnt), 32'd0);
    check("discard_same_cycle_data", IF_Data, 32'h0BAD_C0DE);

    // Timeout on a load.
    ready_en = 1'b0;
    mem_access("lw500_tmo", 1'b0, 2'b00, 32'h0000_0500, 32'h0, 32'h0, ERR, 1'b1, 4'b1111, 32'h0, TMO + 1);
    check("tmo_bus_err", {31'd0, Bus_Err}, 32'd1);
    ready_en = 1'b1;
    fetch("fetch44", 32'h0000_0044, 32'h0123_4567, 1'b1, 2);
    check("bus_err_sticky", {31'd0, Bus_Err}, 32'd1);

    // Reset in the middle of an access.
    ready_en = 1'b0;
    IF_Req = 1'b1; IF_Addr = 32'h0000_0600;
    step(); step();
    check("mid_req_high", {31'd0, Mem_Req}, 32'd1);
    Reset = 1'b1;
    step();
    check("mid_rst_req", {31'd0, Mem_Req}, 32'd0);
    check("mid_rst_bus_err", {31'd0, Bus_Err}, 32'd0);
    check("mid_rst_if_valid", {31'd0, IF_Valid}, 32'd0);
    IF_Req = 1'b0;
    step();
    Reset = 1'b0; ready_en = 1'b1;
    step();
    fetch("fetch48", 32'h0000_0048, 32'hA5A5_A5A5, 1'b1, 2);

    step(); step();
    check("port_q_left", 32'(port_q.size()), 32'd0);
    check("if_q_left", 32'(if_q.size()), 32'd0);
    check("mem_q_left", 32'(mem_q.size()), 32'd0);
    check("misalign_left", 32'(mis_exp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
